// File: rtl/rgb_pkg.sv
// Shared RGB565/RGB888 widths, field offsets and channel expansion helpers.
// RGB565_PACKER_REPLICATE_EN selects MSB replication; otherwise low bits are zero-filled.
package rgb_pkg;

    localparam int unsigned RGB565_R_W = 5;
    localparam int unsigned RGB565_G_W = 6;
    localparam int unsigned RGB565_B_W = 5;
    localparam int unsigned RGB888_W   = 24;
    localparam int unsigned CH_W       = 8;

    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [RGB888_W-1:0] data;
        logic                sof;
        logic                eol;
    } pixel_t;

    localparam int unsigned PIXEL_W = $bits(pixel_t);

    function automatic logic [CH_W-1:0] expand5(input logic [4:0] c);
`ifdef RGB565_PACKER_REPLICATE_EN
        return {c, c[4:2]};
`else
        return {c, 3'b000};
`endif
    endfunction

    function automatic logic [CH_W-1:0] expand6(input logic [5:0] g);
`ifdef RGB565_PACKER_REPLICATE_EN
        return {g, g[5:4]};
`else
        return {g, 2'b00};
`endif
    endfunction

endpackage

// File: rtl/rgb565_packer_skid_buffer.sv
// Two-entry valid/ready skid buffer: main output register plus one skid register.
// Upstream ready is the registered "skid empty" flag, so it never depends combinationally on dn_ready.
module pixel_skid_buffer #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             main_v;
    logic             skid_v;
    logic             up_fire;

    assign up_ready = ~skid_v;
    assign up_fire  = up_valid & ~skid_v;
    assign dn_valid = main_v;
    assign dn_data  = main_q;

    // skid_v implies main_v, so a set skid always drains straight into main.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (dn_ready) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end
        end else if (up_fire) begin
            if (!main_v || dn_ready) begin
                main_q <= up_data;
                main_v <= 1'b1;
            end else begin
                skid_q <= up_data;
                skid_v <= 1'b1;
            end
        end else if (main_v && dn_ready) begin
            main_v <= 1'b0;
        end
    end

endmodule

// File: rtl/rgb565_packer.sv
// RGB565 -> RGB888 streaming packer with raster-derived sof/eol tags and i_sof resync.
// Expansion style set by RGB565_PACKER_REPLICATE_EN (see rgb_pkg).
module rgb565_packer
    import rgb_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [RGB565_R_W-1:0] i_red,
    input  logic [RGB565_G_W-1:0] i_green,
    input  logic [RGB565_B_W-1:0] i_blue,
    input  logic                  i_sof,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [RGB888_W-1:0]   o_data,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_sync_err
);

    localparam int unsigned XW = $clog2(H_ACTIVE);
    localparam int unsigned YW = $clog2(V_ACTIVE);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          accept;
    logic          at_origin;
    logic          last_x;
    logic          last_y;
    logic          sync_err;
    pixel_t        in_pix;
    pixel_t        out_pix;

    assign accept    = i_valid & o_ready;
    assign at_origin = (x == '0) && (y == '0);
    assign last_x    = (x == XW'(H_ACTIVE - 1));
    assign last_y    = (y == YW'(V_ACTIVE - 1));

    always_comb begin
        in_pix                     = '0;
        in_pix.data[R_LSB +: CH_W] = expand5(i_red);
        in_pix.data[G_LSB +: CH_W] = expand6(i_green);
        in_pix.data[B_LSB +: CH_W] = expand5(i_blue);
        // A resync pixel is re-homed to (0,0), which can never be end-of-line.
        in_pix.sof                 = i_sof | at_origin;
        in_pix.eol                 = ~i_sof & last_x;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x        <= '0;
            y        <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= accept & i_sof & ~at_origin;
            if (accept) begin
                if (i_sof) begin
                    x <= XW'(1);
                    y <= '0;
                end else if (last_x) begin
                    x <= '0;
                    y <= last_y ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    pixel_skid_buffer #(
        .WIDTH(PIXEL_W)
    ) u_skid (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .up_valid (i_valid),
        .up_ready (o_ready),
        .up_data  (in_pix),
        .dn_valid (o_valid),
        .dn_ready (i_ready),
        .dn_data  (out_pix)
    );

    assign o_data     = out_pix.data;
    assign o_sof      = out_pix.sof;
    assign o_eol      = out_pix.eol;
    assign o_sync_err = sync_err;

endmodule

// File: tb/tb_rgb565_packer.sv
// Randomised self-checking bench for rgb565_packer against a queue-based reference model.
module tb_rgb565_packer;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_red;
    logic [5:0]  i_green;
    logic [4:0]  i_blue;
    logic        i_sof;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_data;
    logic        o_sof;
    logic        o_eol;
    logic        o_sync_err;

    int checks = 0;
    int errors = 0;

    rgb565_packer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_red      (i_red),
        .i_green    (i_green),
        .i_blue     (i_blue),
        .i_sof      (i_sof),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_sof      (o_sof),
        .o_eol      (o_eol),
        .o_sync_err (o_sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_rgb(input int r, input int g, input int b);
        int rr, gg, bb;
`ifdef RGB565_PACKER_REPLICATE_EN
        rr = r * 8 + r / 4;
        gg = g * 4 + g / 16;
        bb = b * 8 + b / 4;
`else
        rr = r * 8;
        gg = g * 4;
        bb = b * 8;
`endif
        return 24'(rr * 65536 + gg * 256 + bb);
    endfunction

    // Reference model: FIFO of expected words plus linear raster position p.
    logic [25:0] q[$];
    int          p = 0;
    logic        err_pend = 1'b0;
    int          n_rec = 0;
    int          n_sync = 0;
    logic [23:0] rec_data[16];
    logic        rec_sof[16];
    logic        rec_eol[16];

    always @(negedge clk) begin
        logic [25:0] e;
        logic        sof_t, eol_t;
        if (!rst_n) begin
            q.delete();
            p = 0;
            err_pend = 1'b0;
            n_rec = 0;
        end else begin
            check("sync_err", o_sync_err, err_pend);
            if (o_sync_err) n_sync++;
            err_pend = 1'b0;
            check("o_valid", o_valid, q.size() != 0);
            check("o_ready", o_ready, q.size() < 2);
            if (o_valid && i_ready && q.size() != 0) begin
                e = q.pop_front();
                check("o_data", o_data, e[25:2]);
                check("o_sof", o_sof, e[1]);
                check("o_eol", o_eol, e[0]);
                if (n_rec < 16) begin
                    rec_data[n_rec] = o_data;
                    rec_sof[n_rec]  = o_sof;
                    rec_eol[n_rec]  = o_eol;
                end
                n_rec++;
            end
            if (i_valid && o_ready) begin
                if (i_sof) begin
                    err_pend = (p != 0);
                    sof_t = 1'b1;
                    eol_t = (H == 1);
                    p = 1;
                end else begin
                    sof_t = (p == 0);
                    eol_t = (p % H == H - 1);
                    p = (p + 1) % (H * V);
                end
                q.push_back({model_rgb(i_red, i_green, i_blue), sof_t, eol_t});
            end
        end
    end

    task automatic new_pixel();
        i_red   = 5'($urandom);
        i_green = 6'($urandom);
        i_blue  = 5'($urandom);
        i_sof   = 1'b0;
    endtask

    task automatic drive_cycle(input logic rdy, output logic fired, output logic rdy_seen);
        i_ready = rdy;
        @(negedge clk);
        rdy_seen = o_ready;
        fired = i_valid && o_ready;
        @(posedge clk);
        #1;
        if (fired) new_pixel();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       f, rs;
        logic [8:0] sofv, eolv;
        int         stall_fires, sync0, guard;

        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_red = '0; i_green = '0; i_blue = '0; i_sof = 1'b0;
        #2;
        check("rst o_valid", o_valid, 1'b0);
        check("rst o_ready", o_ready, 1'b1);
        check("rst o_data", o_data, 24'h0);
        check("rst o_sof", o_sof, 1'b0);
        check("rst o_eol", o_eol, 1'b0);
        check("rst o_sync_err", o_sync_err, 1'b0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;

        // Expansion literal then one full frame plus one pixel back-to-back.
        i_red = 5'h15; i_green = 6'h3F; i_blue = 5'h01; i_sof = 1'b0; i_valid = 1'b1;
        for (int k = 0; k < 9; k++) drive_cycle(1'b1, f, rs);
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, f, rs);
        check("raster count", n_rec, 9);
`ifdef RGB565_PACKER_REPLICATE_EN
        check("expand literal", rec_data[0], 24'hADFF08);
`else
        check("expand literal", rec_data[0], 24'hA8FC08);
`endif
        for (int k = 0; k < 9; k++) begin
            sofv[k] = rec_sof[k];
            eolv[k] = rec_eol[k];
        end
        check("raster sof pattern", sofv, 9'h101);
        check("raster eol pattern", eolv, 9'h088);

        // Back-pressure: 5 stall cycles in a continuous stream.
        i_valid = 1'b1; new_pixel();
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, f, rs);
        stall_fires = 0;
        for (int s = 0; s < 5; s++) begin
            drive_cycle(1'b0, f, rs);
            check("stall o_ready", rs, s == 0);
            if (f) stall_fires++;
        end
        check("stall accepted", stall_fires, 1);
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, f, rs);

        // Resync on pixel 2 of a line.
        guard = 0;
        while (p % H != 2 && guard < 20) begin
            drive_cycle(1'b1, f, rs);
            guard++;
        end
        check("resync align", p % H, 2);
        sync0 = n_sync;
        i_sof = 1'b1;
        for (int k = 0; k < 6; k++) drive_cycle(1'b1, f, rs);
        check("resync pulses", n_sync - sync0, 1);

        // Random traffic with occasional resync.
        for (int k = 0; k < 400; k++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_red   = 5'($urandom);
            i_green = 6'($urandom);
            i_blue  = 5'($urandom);
            i_sof   = ($urandom_range(0, 15) == 0);
            i_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            @(posedge clk);
            #1;
        end

        // Fill both registers, then reset mid-frame.
        i_sof = 1'b0; i_valid = 1'b1; new_pixel();
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, f, rs);
        check("full before reset", o_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst o_valid", o_valid, 1'b0);
        check("midrst o_ready", o_ready, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        i_valid = 1'b1; new_pixel();
        drive_cycle(1'b1, f, rs);
        i_valid = 1'b0;
        @(negedge clk);
        check("post-rst o_valid", o_valid, 1'b1);
        check("post-rst o_sof", o_sof, 1'b1);
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) drive_cycle(1'b1, f, rs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb565_packer.md
# rgb565_packer

Streaming pixel packer that accepts RGB565 pixels as separate 5/6/5-bit colour components and emits 24-bit RGB888 words on a valid/ready stream. It also generates start-of-frame and end-of-line markers from an active-area raster count. It sits between RGB565 pixel sources (test-pattern, framebuffer read-out) and the 24-bit video path that downstream splitting logic consumes. Full throughput is one pixel per clock, and back-pressure is handled by an internal two-entry skid buffer.

## Interface
Parameters:
- H_ACTIVE, 800, active pixels per line (≥2)
- V_ACTIVE, 480, active lines per frame (≥2)

Ports:
- i_clk  input  1  clock; all logic rising-edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  input pixel valid
- o_ready  output  1  packer can accept a pixel
- i_red  input  5  red component
- i_green  input  6  green component
- i_blue  input  5  blue component
- i_sof  input  1  qualified by i_valid: this pixel is frame pixel (0,0)
- o_valid  output  1  output word valid
- i_ready  input  1  downstream accepts
- o_data  output  24  packed RGB888; [23:16]=R, [15:8]=G, [7:0]=B
- o_sof  output  1  qualified by o_valid: first pixel of frame
- o_eol  output  1  qualified by o_valid: last pixel of line
- o_sync_err  output  1  one-cycle pulse on resync

## Operation
- Input transfer when i_valid && o_ready. Output transfer when o_valid && i_ready.
- Expansion: 5-bit c → {c, c[4:2]}; 6-bit g → {g, g[5:4]} (replication; see Configuration).
- Raster counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) advance per accepted input pixel. They are tagged onto that pixel at acceptance time.
- Each accepted pixel gets sof = (x==0 && y==0) and eol = (x==H_ACTIVE-1).
- x wraps to 0 after H_ACTIVE-1 and increments y. y wraps to 0 after V_ACTIVE-1 when x wraps.
- Resync: an accepted pixel with i_sof=1 is forced to (0,0) and tagged sof=1, and the counters become (1,0).
  - If the counters were not already at (0,0), o_sync_err pulses for one cycle on the following clock.
- Skid buffer: a main output register plus one skid register.
  - o_ready is registered and equals "skid register empty".
  - While i_ready is low with o_valid high, o_data/o_sof/o_eol hold stable.
  - A pixel arriving in the stall cycle goes to the skid register. On the next output transfer the skid register moves to the output and o_ready rises the following cycle.
- Simultaneous input and output transfer with skid empty: the output register reloads directly and o_valid stays high.
- Counter state is not affected by output stalls.

## Timing
- Reset values: o_valid=0, o_data=0, o_sof=0, o_eol=0, o_sync_err=0, o_ready=1, x=y=0, skid empty.
- Latency: input accepted on edge N → o_valid high after edge N, so the word is visible in cycle N+1.
- Throughput: 1 pixel/clock while i_ready=1.
- o_ready falls the cycle after a pixel lands in the skid register. At most one extra pixel is accepted after i_ready drops.
- Reset asserted mid-frame: all state clears immediately (asynchronous). Any buffered pixels are discarded, and the first pixel after reset is tagged sof.
- Reset deassertion must be synchronised externally to i_clk.

## Configuration
- Macro RGB565_PACKER_REPLICATE_EN.
  - Defined: low bits filled by MSB replication as above, so full scale maps to 8'hFF.
  - Undefined: low bits zero-filled: R={r,3'b000}, G={g,2'b00}, B={b,3'b000}.
- Counters, handshake and latency are identical in both builds.

## Structure
- Shared package rgb_pkg holds:
  - width constants RGB565_R_W=5, RGB565_G_W=6, RGB565_B_W=5, RGB888_W=24
  - field-offset constants R_LSB=16, G_LSB=8, B_LSB=0
  - expansion functions expand5/expand6, with bodies selected by the macro
- One sub-module: pixel_skid_buffer, parameterised on payload width, holding 26 bits (24 data + sof + eol). The top contains only expansion, counters and resync logic.

## Test plan
- Expansion, replication build: R=5'h15, G=6'h3F, B=5'h01 → o_data=24'hADFF08. Zero-fill build: R=5'h15, G=6'h3F, B=5'h01 → 24'hA8FC08.
- Raster, H_ACTIVE=4, V_ACTIVE=2: 8 back-to-back pixels → o_sof only on pixel 0, o_eol on pixels 3 and 7; pixel 8 → o_sof again.
- Back-pressure: i_ready low for 5 cycles during a continuous stream → o_ready low from the 2nd stall cycle, exactly one pixel buffered, no loss or duplication, order preserved.
- Resync: i_sof on pixel 2 of a line → that pixel has o_sof=1, o_sync_err pulses once, next eol is at pixel 2+H_ACTIVE-1.
- Reset mid-frame: assert i_rst_n=0 with both registers full → o_valid=0 and o_ready=1 immediately; first post-reset pixel has o_sof=1.
